// File: rtl/pc_gen.sv
// Fetch-stage PC register and next-PC generator. Buffers one resolved control
// transfer (optionally behind a delay-slot fetch) and handles exception entry/eret.
module pc_gen #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_PC     = 32'h0000_4180,
  parameter int          DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch_ready,
  input  logic              i_stall,
  input  logic              i_redir_valid,
  input  logic [1:0]        i_npc_op,
  input  logic [ADDR_W-1:0] i_br_pc,
  input  logic [25:0]       i_d_ins26,
  input  logic [31:0]       i_d_ext32,
  input  logic [31:0]       i_d_rfrs32,
  input  logic              i_exc_req,
  input  logic              i_eret_req,
  input  logic [ADDR_W-1:0] i_epc_in,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fetch_valid,
  output logic [ADDR_W-1:0] o_epc_out,
  output logic              o_bd_out,
  output logic              o_align_err
);

  typedef enum logic [1:0] {S_SEQ, S_SLOT, S_HOLD} state_t;

  localparam logic [ADDR_W-1:0] P_RESET = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] P_EXC   = EXC_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] P_FOUR  = ADDR_W'(4);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;
  logic              r_fetch_valid;
  logic [ADDR_W-1:0] r_epc;
  logic              r_bd;
  logic              r_align_err;

  logic              w_adv, w_take, w_in_branch;
  logic [ADDR_W-1:0] w_base, w_rel, w_abs, w_reg, w_target, w_pc_inc;
  logic              w_unused;

  assign w_unused = ^{i_d_ext32, i_d_rfrs32};

  assign w_adv    = r_fetch_valid & i_fetch_ready & ~i_stall;
  assign w_base   = i_br_pc + P_FOUR;
  assign w_rel    = w_base + {i_d_ext32[ADDR_W-3:0], 2'b00};
  assign w_reg    = i_d_rfrs32[ADDR_W-1:0];
  assign w_pc_inc = r_pc + P_FOUR;

  generate
    if (ADDR_W == 28) begin : g_abs28
      assign w_abs = {i_d_ins26, 2'b00};
    end else begin : g_abs
      assign w_abs = {w_base[ADDR_W-1:28], i_d_ins26, 2'b00};
    end
  endgenerate

  always_comb begin
    w_target = w_reg;
    case (i_npc_op)
      2'b01:   w_target = w_rel;
      2'b10:   w_target = w_abs;
      default: w_target = w_reg;
    endcase
  end

  // Only one transfer may be outstanding; exc/eret pre-empt any new redirect.
  assign w_take = i_redir_valid & (i_npc_op != 2'b00) & (r_state == S_SEQ)
                & ~i_exc_req & ~i_eret_req;
  assign w_in_branch = (DELAY_SLOT != 0) & (r_state != S_SEQ);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    if (i_exc_req) begin
      w_pc_nxt    = P_EXC;
      w_state_nxt = S_SEQ;
      w_tgt_nxt   = '0;
    end else if (i_eret_req) begin
      w_pc_nxt    = i_epc_in;
      w_state_nxt = S_SEQ;
      w_tgt_nxt   = '0;
    end else begin
      case (r_state)
        S_SEQ: begin
          if (w_adv) w_pc_nxt = w_pc_inc;
          if (w_take) begin
            w_tgt_nxt = w_target;
            // A delay-slot fetch in the redirect cycle itself skips SLOT.
            w_state_nxt = ((DELAY_SLOT != 0) && !w_adv) ? S_SLOT : S_HOLD;
          end
        end
        S_SLOT: begin
          if (w_adv) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_adv) begin
            w_pc_nxt    = r_tgt;
            w_state_nxt = S_SEQ;
          end
        end
        default: w_state_nxt = S_SEQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_SEQ;
      r_pc          <= P_RESET;
      r_tgt         <= '0;
      r_fetch_valid <= 1'b0;
      r_epc         <= '0;
      r_bd          <= 1'b0;
      r_align_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_tgt         <= w_tgt_nxt;
      r_fetch_valid <= 1'b1;
      r_align_err   <= w_take & (i_npc_op == 2'b11) & (i_d_rfrs32[1:0] != 2'b00);
      if (i_exc_req) begin
        r_epc <= w_in_branch ? i_br_pc : r_pc;
        r_bd  <= w_in_branch;
      end else if (i_eret_req) begin
        r_bd  <= 1'b0;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_fetch_valid = r_fetch_valid;
  assign o_epc_out     = r_epc;
  assign o_bd_out      = r_bd;
  assign o_align_err   = r_align_err;

endmodule
